// File: rtl/vga_mem_reader.sv
`default_nettype none
// ============================================================================
// Module   : vga_mem_reader
// Purpose  : VGA raster generator that fetches one word per display cell from
//            a synchronous read port and drives registered RGB332 video.
// Revision : 1.0  initial release
// ============================================================================
module vga_mem_reader #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int CELL_SHIFT = 5,
  parameter int ADDR_W     = 16,
  parameter int BASE_ADDR  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [31:0]       rd_data,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              de,
  output logic [7:0]        rgb,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int COLS    = H_ACTIVE >> CELL_SHIFT;
  localparam int HW      = $clog2(H_TOTAL + 3);
  localparam int VW      = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0]     c_h_total   = HW'(H_TOTAL);
  localparam logic [HW-1:0]     c_h_last    = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0]     c_h_active  = HW'(H_ACTIVE);
  localparam logic [HW-1:0]     c_hs_start  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0]     c_hs_end    = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0]     c_cols_last = HW'(COLS - 1);
  localparam logic [HW-1:0]     c_lead      = HW'(3);
  localparam logic [VW-1:0]     c_v_last    = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0]     c_v_active  = VW'(V_ACTIVE);
  localparam logic [VW-1:0]     c_vs_start  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0]     c_vs_end    = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [ADDR_W-1:0] c_base      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] c_cols      = ADDR_W'(COLS);

  logic [HW-1:0]     r_h;
  logic [VW-1:0]     r_v;
  logic [ADDR_W-1:0] r_row_base;
  logic              r_rd_pend;
  logic [7:0]        r_cell_q;

  logic [HW-1:0]     w_hsum;
  logic              w_hwrap;
  logic [HW-1:0]     w_hp;
  logic [VW-1:0]     w_vp;
  logic [HW-1:0]     w_col;
  logic              w_fetch;
  logic              w_first;
  logic              w_row_end;
  logic [ADDR_W-1:0] w_base;
  logic              w_vis;
  logic              w_hs;
  logic              w_vs;
  logic              w_unused;

  assign w_unused = ^rd_data[31:8];

  // Fetch decisions look three pixels ahead: decide, strobe the port, capture
  // the data, so the cell register is loaded as the raster reaches the cell.
  always_comb begin
    w_hsum  = r_h + c_lead;
    w_hwrap = (w_hsum >= c_h_total);
    w_hp    = w_hwrap ? (w_hsum - c_h_total) : w_hsum;
    if (!w_hwrap)
      w_vp = r_v;
    else if (r_v == c_v_last)
      w_vp = '0;
    else
      w_vp = r_v + VW'(1);
    w_col     = w_hp >> CELL_SHIFT;
    w_fetch   = run && (w_hp < c_h_active) && (w_hp[CELL_SHIFT-1:0] == '0)
                && (w_vp < c_v_active);
    w_first   = (w_vp == '0) && (w_col == '0);
    w_row_end = (w_col == c_cols_last) && (&w_vp[CELL_SHIFT-1:0]);
    w_base    = w_first ? c_base : r_row_base;
    w_vis     = (r_h < c_h_active) && (r_v < c_v_active);
    w_hs      = (r_h >= c_hs_start) && (r_h < c_hs_end);
    w_vs      = (r_v >= c_vs_start) && (r_v < c_vs_end);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_h         <= '0;
      r_v         <= '0;
      r_row_base  <= c_base;
      r_rd_pend   <= 1'b0;
      r_cell_q    <= 8'h00;
      rd_en       <= 1'b0;
      rd_addr     <= c_base;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      rgb         <= 8'h00;
      frame_start <= 1'b0;
    end else if (!run) begin
      r_h         <= '0;
      r_v         <= '0;
      r_row_base  <= c_base;
      r_rd_pend   <= 1'b0;
      r_cell_q    <= 8'h00;
      rd_en       <= 1'b0;
      hsync_n     <= 1'b1;
      vsync_n     <= 1'b1;
      de          <= 1'b0;
      rgb         <= 8'h00;
      frame_start <= 1'b0;
    end else begin
      if (r_h == c_h_last) begin
        r_h <= '0;
        r_v <= (r_v == c_v_last) ? '0 : r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end

      rd_en     <= w_fetch;
      r_rd_pend <= rd_en;
      if (w_fetch) begin
        rd_addr    <= w_base + ADDR_W'(w_col);
        r_row_base <= w_row_end ? (w_base + c_cols) : w_base;
      end
      if (r_rd_pend)
        r_cell_q <= rd_data[7:0];

      hsync_n     <= !w_hs;
      vsync_n     <= !w_vs;
      de          <= w_vis;
      rgb         <= w_vis ? r_cell_q : 8'h00;
      frame_start <= (r_h == '0) && (r_v == '0);
    end
  end

endmodule
`default_nettype wire
